// File: rtl/dt_sweep_pkg.sv
// Shared types for the decision-tree input sweeper.
// Holds FSM states, default widths and the in-flight tag layout.
package dt_sweep_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [DEF_IN_W-1:0] value;
  } tag_t;

endpackage

// File: rtl/dt_tag_pipe.sv
// LAT-deep tag shift register with synchronous flush.
// Keeps candidate tags aligned with a registered classifier.
module dt_tag_pipe
  import dt_sweep_pkg::*;
#(
  parameter int  LAT = 1,
  parameter type T   = tag_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  T     tag_i,
  output T     tag_o
);

  T stage_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        stage_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < LAT; i++)
        stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/dt_preimage_finder.sv
// Sweeps every input through an external classifier and reports
// the lowest input hitting a target class plus the hit count.
module dt_preimage_finder
  import dt_sweep_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_target,
  input  logic             req_stop_first,
  output logic [IN_W-1:0]  cand_o,
  output logic             cand_valid,
  input  logic [OUT_W-1:0] cls_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_found,
  output logic [IN_W-1:0]  res_first,
  output logic [IN_W:0]    res_count
);

  typedef struct packed {
    logic            valid;
    logic [IN_W-1:0] value;
  } ptag_t;

  localparam logic [IN_W:0] LAST  = (IN_W+1)'((1 << IN_W) - 1);
  localparam logic [IN_W:0] DLAST = (IN_W+1)'(LAT - 1);

  state_e           st_q, st_d;
  logic [IN_W:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] tgt_q, tgt_d;
  logic             stop_q, stop_d;
  logic             found_q, found_d;
  logic [IN_W-1:0]  first_q, first_d;
  logic [IN_W:0]    count_q, count_d;

  ptag_t tag_in, tag_out;
  logic  hit, halt, flush;

  assign hit  = tag_out.valid && (cls_i == tgt_q);
  assign halt = hit && stop_q;

  assign tag_in.valid = cand_valid;
  assign tag_in.value = cnt_q[IN_W-1:0];

  dt_tag_pipe #(
    .LAT (LAT),
    .T   (ptag_t)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      stop_q  <= 1'b0;
      found_q <= 1'b0;
      first_q <= '0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      stop_q  <= stop_d;
      found_q <= found_d;
      first_q <= first_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    stop_d     = stop_q;
    found_d    = found_q;
    first_d    = first_q;
    count_d    = count_q;
    req_ready  = 1'b0;
    cand_valid = 1'b0;
    res_valid  = 1'b0;
    flush      = 1'b0;

    if (hit) begin
      count_d = count_q + 1'b1;
      if (!found_q) begin
        found_d = 1'b1;
        first_d = tag_out.value;
      end
    end

    unique case (st_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tgt_d   = req_target;
          stop_d  = req_stop_first;
          cnt_d   = '0;
          count_d = '0;
          found_d = 1'b0;
          first_d = '0;
          st_d    = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (halt) begin
          flush = 1'b1;
          st_d  = S_DONE;
        end else begin
          cand_valid = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // counter is reused to time the drain
            cnt_d = '0;
            st_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (halt) begin
          flush = 1'b1;
          st_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DLAST)
            st_d = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign cand_o    = cnt_q[IN_W-1:0];
  assign res_found = found_q;
  assign res_first = first_q;
  assign res_count = count_q;

endmodule

// File: tb/tb_dt_preimage_finder.sv
// Self-checking bench: two sweepers (LAT=1, LAT=3) against a
// behavioural classifier and a brute-force reference model.
module tb_dt_preimage_finder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] req_target = '0;
  logic       req_stop = 1'b0;
  logic       res_ready = 1'b0;
  logic       rv1 = 1'b0, rv3 = 1'b0;
  logic       sel = 1'b0;
  int         mode = 0;
  int         checks = 0;
  int         errors = 0;

  logic       rr1, cv1, resv1, found1;
  logic [7:0] cand1, first1;
  logic [8:0] count1;
  logic       rr3, cv3, resv3, found3;
  logic [7:0] cand3, first3;
  logic [8:0] count3;
  logic [6:0] cls1 = '0;
  logic [6:0] p3 [3] = '{default: '0};

  always #5 clk = ~clk;

  function automatic logic [6:0] f(input int md, input logic [7:0] x);
    return (md == 0) ? (x[6:0] ^ 7'h55) : 7'h00;
  endfunction

  always @(posedge clk) begin
    cls1  <= f(mode, cand1);
    p3[0] <= f(mode, cand3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  dt_preimage_finder #(.IN_W(8), .OUT_W(7), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
    .req_target(req_target), .req_stop_first(req_stop),
    .cand_o(cand1), .cand_valid(cv1), .cls_i(cls1),
    .res_valid(resv1), .res_ready(res_ready), .res_found(found1),
    .res_first(first1), .res_count(count1)
  );

  dt_preimage_finder #(.IN_W(8), .OUT_W(7), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3),
    .req_target(req_target), .req_stop_first(req_stop),
    .cand_o(cand3), .cand_valid(cv3), .cls_i(p3[2]),
    .res_valid(resv3), .res_ready(res_ready), .res_found(found3),
    .res_first(first3), .res_count(count3)
  );

  wire       m_rr   = sel ? rr3 : rr1;
  wire       m_cv   = sel ? cv3 : cv1;
  wire       m_resv = sel ? resv3 : resv1;
  wire       m_fnd  = sel ? found3 : found1;
  wire [7:0] m_cand = sel ? cand3 : cand1;
  wire [7:0] m_fst  = sel ? first3 : first1;
  wire [8:0] m_cnt  = sel ? count3 : count1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, m_rr, 1);
    chk({tag, ".cand_valid"}, m_cv, 0);
    chk({tag, ".cand_o"}, m_cand, 0);
    chk({tag, ".res_valid"}, m_resv, 0);
    chk({tag, ".res_found"}, m_fnd, 0);
    chk({tag, ".res_first"}, m_fst, 0);
    chk({tag, ".res_count"}, m_cnt, 0);
  endtask

  task automatic sweep(input bit s3, input int md, input logic [6:0] tgt,
                       input bit stop, input int hold);
    int lat, e_cnt, e_first, e_lat, e_iss;
    int n, issued, seq_bad;
    bit done;
    lat = s3 ? 3 : 1;
    e_cnt = 0;
    e_first = -1;
    for (int x = 0; x < 256; x++) begin
      if (f(md, 8'(x)) == tgt) begin
        e_cnt++;
        if (e_first < 0) e_first = x;
      end
    end
    if (stop && e_cnt > 0) begin
      e_cnt = 1;
      e_lat = e_first + lat + 2;
      e_iss = (e_first + lat > 256) ? 256 : e_first + lat;
    end else begin
      e_lat = 256 + lat + 1;
      e_iss = 256;
    end
    if (e_first < 0) e_first = 0;

    @(negedge clk);
    sel = s3;
    mode = md;
    req_target = tgt;
    req_stop = stop;
    res_ready = 1'b0;
    chk("idle.req_ready", m_rr, 1);
    if (s3) rv3 = 1'b1; else rv1 = 1'b1;
    @(posedge clk);
    #1 rv1 = 1'b0;
    rv3 = 1'b0;
    n = 0; issued = 0; seq_bad = 0; done = 0;
    while (!done && n < 700) begin
      @(negedge clk);
      n++;
      if (m_cv) begin
        if (m_cand !== issued[7:0]) seq_bad++;
        issued++;
      end
      if (m_resv) done = 1;
    end
    chk("res_latency", n, e_lat);
    chk("issued", issued, e_iss);
    chk("cand_seq_errs", seq_bad, 0);
    chk("res_found", m_fnd, (e_cnt > 0) ? 1 : 0);
    chk("res_first", m_fst, e_first);
    chk("res_count", m_cnt, e_cnt);
    chk("done.req_ready", m_rr, 0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (s3) rv3 = i[0]; else rv1 = i[0];
      chk("hold.res_valid", m_resv, 1);
      chk("hold.req_ready", m_rr, 0);
      chk("hold.res_count", m_cnt, e_cnt);
      chk("hold.res_first", m_fst, e_first);
      chk("hold.cand_valid", m_cv, 0);
    end
    @(negedge clk);
    rv1 = 1'b0;
    rv3 = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("post.res_valid", m_resv, 0);
    chk("post.req_ready", m_rr, 1);
  endtask

  initial begin
    int n;
    #2;
    sel = 1'b0;
    #1 chk_reset_outputs("rst1");
    sel = 1'b1;
    #1 chk_reset_outputs("rst3");
    @(negedge clk);
    rst = 1'b0;

    sweep(0, 0, 7'h55, 0, 0);
    sweep(0, 0, 7'h2A, 1, 0);
    sweep(0, 1, 7'h01, 0, 0);
    sweep(0, 1, 7'h00, 0, 0);
    sweep(1, 0, 7'h55, 1, 0);
    sweep(0, 0, 7'h55, 0, 10);

    @(negedge clk);
    sel = 1'b0;
    mode = 0;
    req_target = 7'h55;
    req_stop = 1'b0;
    rv1 = 1'b1;
    @(posedge clk);
    #1 rv1 = 1'b0;
    n = 0;
    while (!(m_cv && m_cand == 8'h40) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid.reached_0x40", m_cand, 8'h40);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 0, 7'h55, 0, 0);

    for (int i = 0; i < 3; i++)
      sweep(0, int'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 3; i++)
      sweep(1, int'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
